// File: rtl/merge_out_serializer.sv
// Word FIFO behind the 32-lane merger root, emitting each word as OUT_RECS-record beats.
// Optional key-order checker is built only when the SORT_CHECK_EN macro is defined.
module merge_out_serializer #(
   parameter int DATA_WIDTH = 128,
   parameter int KEY_WIDTH  = 80,
   parameter int IN_RECS    = 32,
   parameter int OUT_RECS   = 4,
   parameter int DEPTH      = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [IN_RECS*DATA_WIDTH-1:0]  i_data,
   input  logic                           i_write,
   output logic                           o_ready,
   output logic [OUT_RECS*DATA_WIDTH-1:0] o_data,
   output logic                           o_valid,
   output logic                           o_last,
   input  logic                           i_ready,
   output logic [31:0]                    o_word_count,
   output logic                           o_order_err
);
   localparam int BEATS  = IN_RECS / OUT_RECS;
   localparam int BEAT_W = OUT_RECS * DATA_WIDTH;
   localparam int WORD_W = IN_RECS * DATA_WIDTH;
   localparam int AW     = $clog2(DEPTH);
   localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
   localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

   if ((IN_RECS % OUT_RECS) != 0 || KEY_WIDTH > DATA_WIDTH || DEPTH < 2 || (1 << AW) != DEPTH)
   begin : g_param_check
      $error("merge_out_serializer: illegal parameter combination");
   end

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [IW-1:0]     r_idx;
   logic [31:0]       r_word_count;
   logic              w_push;
   logic              w_beat;
   logic              w_pop;
   logic [WORD_W-1:0] w_head;

   // o_ready looks only at the registered count, so a pop never frees a slot in the same cycle
   assign o_ready      = (r_count != FULL);
   assign o_valid      = (r_count != '0);
   assign w_head       = r_mem[r_rd_ptr];
   assign o_data       = w_head[int'(r_idx) * BEAT_W +: BEAT_W];
   assign o_last       = o_valid & (r_idx == LAST_IDX);
   assign o_word_count = r_word_count;

   assign w_push = i_write & o_ready;
   assign w_beat = o_valid & i_ready;
   assign w_pop  = w_beat & (r_idx == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_idx        <= '0;
         r_word_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_beat) begin
            r_idx <= w_pop ? '0 : r_idx + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_word_count <= r_word_count + 32'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef SORT_CHECK_EN
   logic [KEY_WIDTH-1:0] r_last_key;
   logic                 r_seen;
   logic                 r_order_err;
   logic [KEY_WIDTH-1:0] w_keys [OUT_RECS];
   logic                 w_viol;

   // Keys are checked in stream order: carried key from the previous beat, then rec0..recN-1
   always_comb begin
      for (int j = 0; j < OUT_RECS; j++) begin
         w_keys[j] = o_data[j*DATA_WIDTH + DATA_WIDTH - KEY_WIDTH +: KEY_WIDTH];
      end
      w_viol = r_seen && (w_keys[0] < r_last_key);
      for (int j = 1; j < OUT_RECS; j++) begin
         if (w_keys[j] < w_keys[j-1]) begin
            w_viol = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last_key  <= '0;
         r_seen      <= 1'b0;
         r_order_err <= 1'b0;
      end else if (w_beat) begin
         r_last_key <= w_keys[OUT_RECS-1];
         r_seen     <= 1'b1;
         if (w_viol) begin
            r_order_err <= 1'b1;
         end
      end
   end

   assign o_order_err = r_order_err;
`else
   assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_out_serializer.sv
// Randomised and directed bench for merge_out_serializer against a beat-queue reference model.
module tb_merge_out_serializer;
   localparam int DW    = 128;
   localparam int KW    = 80;
   localparam int IR    = 32;
   localparam int ORC   = 4;
   localparam int DEPTH = 4;
   localparam int BEATS = IR / ORC;
   localparam int BW    = ORC * DW;
   localparam int WW    = IR * DW;
`ifdef SORT_CHECK_EN
   localparam bit SORT_ON = 1'b1;
`else
   localparam bit SORT_ON = 1'b0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [WW-1:0] i_data = '0;
   logic          i_write = 1'b0;
   logic          i_ready = 1'b0;
   logic          o_ready, o_valid, o_last, o_order_err;
   logic [BW-1:0] o_data;
   logic [31:0]   o_word_count;

   merge_out_serializer #(
      .DATA_WIDTH(DW), .KEY_WIDTH(KW), .IN_RECS(IR), .OUT_RECS(ORC), .DEPTH(DEPTH)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_write(i_write), .o_ready(o_ready),
      .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
      .o_word_count(o_word_count), .o_order_err(o_order_err)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int unsigned nk = 0;

   // reference model: every accepted word becomes BEATS queued beats
   logic [BW-1:0] q_beat [$];
   bit            q_last [$];
   logic [31:0]   m_wc;
   bit            m_err, m_seen;
   logic [KW-1:0] m_last_key;

   logic          s_ready, s_valid, s_last, s_err, e_ready, e_valid, e_last, e_err;
   logic [BW-1:0] s_data, e_data;
   logic [31:0]   s_wc, e_wc;

   function automatic int held_words();
      return (q_beat.size() + BEATS - 1) / BEATS;
   endfunction

   function automatic logic [WW-1:0] mk(input int unsigned base);
      logic [WW-1:0] w;
      logic [63:0]   p;
      for (int r = 0; r < IR; r++) begin
         p = {$urandom, $urandom};
         w[r*DW +: DW] = {48'd0, 32'(base + r), p[47:0]};
      end
      return w;
   endfunction

   task automatic model_clear();
      q_beat.delete();
      q_last.delete();
      m_wc = '0;
      m_err = 1'b0;
      m_seen = 1'b0;
      m_last_key = '0;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_write = 1'b0;
      i_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   // one clock: drive, sample at negedge, record model expectation, advance model
   task automatic cyc(input logic wr, input logic [WW-1:0] d, input logic rdy);
      logic [BW-1:0] b;
      logic [KW-1:0] k;
      i_write = wr;
      i_data  = d;
      i_ready = rdy;
      @(negedge i_clk);
      s_ready = o_ready; s_valid = o_valid; s_last = o_last; s_err = o_order_err;
      s_data = o_data; s_wc = o_word_count;
      e_ready = (held_words() < DEPTH);
      e_valid = (q_beat.size() != 0);
      e_last  = e_valid && q_last[0];
      e_data  = e_valid ? q_beat[0] : '0;
      e_wc    = m_wc;
      e_err   = m_err;
      if (e_valid && rdy) begin
         b = q_beat.pop_front();
         if (q_last.pop_front()) m_wc = m_wc + 32'd1;
         for (int j = 0; j < ORC; j++) begin
            k = b[j*DW + DW - KW +: KW];
            if (SORT_ON && m_seen && k < m_last_key) m_err = 1'b1;
            m_last_key = k;
            m_seen = 1'b1;
         end
      end
      if (wr && e_ready) begin
         for (int i = 0; i < BEATS; i++) begin
            q_beat.push_back(d[i*BW +: BW]);
            q_last.push_back(i == BEATS - 1);
         end
      end
      @(posedge i_clk);
      #1 i_write = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      model_clear();
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      n_tests++;
      if ({o_ready, o_valid, o_last, o_order_err} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctl got rdy/vld/last/err=%b required 1000", {o_ready, o_valid, o_last, o_order_err});
      end
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      n_tests++;
      if ({o_ready, o_valid, o_word_count, o_order_err} !== {2'b10, 32'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_idle got rdy=%b vld=%b wc=%0d err=%b required 1 0 0 0", o_ready, o_valid, o_word_count, o_order_err);
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_single_word();
      logic [WW-1:0] w;
      int first = -1, nb = 0, nl = 0;
      w = mk(0);
      nk = 32;
      for (int c = 0; c < 11; c++) begin
         cyc(c == 0, w, 1'b1);
         if (s_valid && first < 0) first = c;
         nb += int'(s_valid);
         nl += int'(s_last);
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err} !== {e_ready, e_valid, e_last, e_err}) begin
            n_fail++;
            $display("FAIL single_ctl c=%0d got %b required %b", c, {s_ready, s_valid, s_last, s_err}, {e_ready, e_valid, e_last, e_err});
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL single_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
      end
      n_tests++;
      if (first !== 1 || nb !== BEATS || nl !== 1 || s_wc !== 32'd1) begin
         n_fail++;
         $display("FAIL single_summary got first=%0d beats=%0d lasts=%0d wc=%0d required 1 8 1 1", first, nb, nl, s_wc);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] wc0;
      int nb = 0;
      wc0 = m_wc;
      for (int c = 0; c < 38; c++) begin
         cyc(c < 5, mk(nk), c >= 5);
         if (c < 5) nk += 32;
         if (s_valid && c >= 5) nb++;
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err} !== {e_ready, e_valid, e_last, e_err}) begin
            n_fail++;
            $display("FAIL bp_ctl c=%0d got %b required %b", c, {s_ready, s_valid, s_last, s_err}, {e_ready, e_valid, e_last, e_err});
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL bp_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
         if (c == 4) begin
            n_tests++;
            if (s_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_full got o_ready=%b required 0", s_ready);
            end
         end
      end
      n_tests++;
      if (nb !== 32 || s_wc !== wc0 + 32'd4) begin
         n_fail++;
         $display("FAIL bp_summary got beats=%0d wc=%0d required 32 %0d", nb, s_wc, wc0 + 32'd4);
      end
   endtask

   task automatic test_stall_toggle();
      logic [WW-1:0] w;
      logic [BW-1:0] p_data = '0;
      logic          p_valid = 1'b0, p_rdy = 1'b0, rdy;
      w = mk(nk);
      nk += 32;
      for (int c = 0; c < 22; c++) begin
         rdy = (c > 0) && c[0];
         cyc(c == 0, w, rdy);
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err, s_wc} !== {e_ready, e_valid, e_last, e_err, e_wc}) begin
            n_fail++;
            $display("FAIL stall_ctl c=%0d got %b/%0d required %b/%0d", c, {s_ready, s_valid, s_last, s_err}, s_wc, {e_ready, e_valid, e_last, e_err}, e_wc);
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL stall_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
         if (p_valid && !p_rdy) begin
            n_tests++;
            if (s_valid !== 1'b1 || s_data !== p_data) begin
               n_fail++;
               $display("FAIL stall_hold c=%0d got vld=%b data=%h required 1 %h", c, s_valid, s_data, p_data);
            end
         end
         p_valid = s_valid; p_data = s_data; p_rdy = rdy;
      end
   endtask

   task automatic test_sort_check();
      logic [WW-1:0] w1, w2;
      do_reset();
      w1 = mk(0);
      w2 = mk(10);
      for (int c = 0; c < 20; c++) begin
         cyc(c < 2, (c == 0) ? w1 : w2, 1'b1);
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err, s_wc} !== {e_ready, e_valid, e_last, e_err, e_wc}) begin
            n_fail++;
            $display("FAIL sort_ctl c=%0d got %b/%0d required %b/%0d", c, {s_ready, s_valid, s_last, s_err}, s_wc, {e_ready, e_valid, e_last, e_err}, e_wc);
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL sort_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
      end
      n_tests++;
      if (s_err !== SORT_ON || s_wc !== 32'd2) begin
         n_fail++;
         $display("FAIL sort_final got err=%b wc=%0d required %b 2", s_err, s_wc, SORT_ON);
      end
   endtask

   task automatic test_reset_midstream();
      for (int c = 0; c < 5; c++) begin
         cyc(c < 2, mk(1000 + 32 * c), c >= 2);
      end
      i_rst = 1'b1;
      #1;
      n_tests++;
      if ({o_valid, o_ready, o_last, o_order_err} !== 4'b0100 || o_word_count !== 32'd0) begin
         n_fail++;
         $display("FAIL midrst_async got vld/rdy/last/err=%b wc=%0d required 0100 0", {o_valid, o_ready, o_last, o_order_err}, o_word_count);
      end
      model_clear();
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      for (int c = 0; c < 11; c++) begin
         cyc(c == 0, mk(5), 1'b1);
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err, s_wc} !== {e_ready, e_valid, e_last, e_err, e_wc}) begin
            n_fail++;
            $display("FAIL midrst_ctl c=%0d got %b/%0d required %b/%0d", c, {s_ready, s_valid, s_last, s_err}, s_wc, {e_ready, e_valid, e_last, e_err}, e_wc);
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL midrst_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
      end
   endtask

   task automatic test_random();
      logic wr, rdy;
      do_reset();
      for (int c = 0; c < 700; c++) begin
         wr  = (c < 600) && ($urandom_range(0, 2) == 0);
         rdy = (c >= 600) || ($urandom_range(0, 3) != 0);
         cyc(wr, mk($urandom_range(0, 2000)), rdy);
         n_tests++;
         if ({s_ready, s_valid, s_last, s_err, s_wc} !== {e_ready, e_valid, e_last, e_err, e_wc}) begin
            n_fail++;
            $display("FAIL rand_ctl c=%0d got %b/%0d required %b/%0d", c, {s_ready, s_valid, s_last, s_err}, s_wc, {e_ready, e_valid, e_last, e_err}, e_wc);
         end
         if (e_valid) begin
            n_tests++;
            if (s_data !== e_data) begin
               n_fail++;
               $display("FAIL rand_data c=%0d got %h required %h", c, s_data, e_data);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_stall_toggle();
      test_sort_check();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
